nibble_serializer: RTL and testbench

//  Parallel-to-serial stage that sits directly upstream of mux4 and drives its
//  in and select inputs. Accepts one 4-bit word per valid/ready handshake,

---
 rtl/nibble_serializer_pkg.sv | 23 ++
 rtl/nibble_serializer_if.sv | 26 ++
 rtl/nibble_serializer_mux4.sv | 12 +
 rtl/nibble_serializer.sv | 122 ++++++++++++
 tb/tb_nibble_serializer.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/nibble_serializer_pkg.sv
// rtl/nibble_serializer_pkg.sv - shared types and constants for the nibble serializer (SERIALIZER_PARITY_EN adds the parity beat)
package serializer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam int WORD_W = 4;
  localparam int SEL_W  = 2;

`ifdef SERIALIZER_PARITY_EN
  localparam int BEATS_PER_WORD = WORD_W + 1;
`else
  localparam int BEATS_PER_WORD = WORD_W;
`endif

  function automatic logic even_parity(input logic [WORD_W-1:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/nibble_serializer_if.sv
// rtl/nibble_serializer_if.sv - word-in / bit-out handshake bundle for nibble_serializer
interface nibble_serializer_if;
  import serializer_pkg::*;

  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              out_bit;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              busy;

  // master: the environment supplying words and consuming bits
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_bit, out_valid, out_last, busy
  );

  // slave: the serializer itself
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_bit, out_valid, out_last, busy
  );

endinterface

// File: rtl/nibble_serializer_mux4.sv
// rtl/nibble_serializer_mux4.sv - 4:1 bit mux picking one bit of the held word
module mux4
  import serializer_pkg::*;
(
  input  logic [WORD_W-1:0] in,
  input  logic [SEL_W-1:0]  select,
  output logic              out
);

  assign out = in[select];

endmodule

// File: rtl/nibble_serializer.sv
// rtl/nibble_serializer.sv - 4-bit parallel to 1-bit serial stage driving mux4
// Optional SERIALIZER_PARITY_EN appends an even-parity beat and moves out_last onto it.
module nibble_serializer
  import serializer_pkg::*;
#(
  parameter int LSB_FIRST = 1
) (
  input  logic                clk,
  input  logic                rst,
  nibble_serializer_if.slave  bus
);

  state_t             state, state_nx;
  logic [SEL_W-1:0]   idx, idx_nx;
  logic [SEL_W-1:0]   sel, sel_nx;
  logic [WORD_W-1:0]  word, word_nx;
  logic               mux_bit;
  logic               out_valid_c;
  logic               out_last_c;
  logic               beat_fire;
  logic               in_ready_c;
  logic               accept;

  function automatic logic [SEL_W-1:0] sel_of(input logic [SEL_W-1:0] i);
    return (LSB_FIRST != 0) ? i : (2'd3 - i);
  endfunction

  mux4 u_mux (
    .in     (word),
    .select (sel),
    .out    (mux_bit)
  );

  always_comb begin
    out_valid_c = (state != IDLE);
`ifdef SERIALIZER_PARITY_EN
    out_last_c  = (state == PARITY);
`else
    out_last_c  = (state == SHIFT) && (idx == 2'd3);
`endif
    beat_fire   = out_valid_c && bus.out_ready;
    // Accepting on the last beat's handshake keeps back-to-back words bubble-free.
    in_ready_c  = (state == IDLE) || (out_last_c && beat_fire);
    accept      = bus.in_valid && in_ready_c;
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    sel_nx   = sel;
    word_nx  = word;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = SHIFT;
          idx_nx   = '0;
          sel_nx   = sel_of('0);
          word_nx  = bus.in_data;
        end
      end
      SHIFT: begin
        if (beat_fire) begin
          if (idx == 2'd3) begin
`ifdef SERIALIZER_PARITY_EN
            state_nx = PARITY;
`else
            if (accept) begin
              state_nx = SHIFT;
              idx_nx   = '0;
              sel_nx   = sel_of('0);
              word_nx  = bus.in_data;
            end else begin
              state_nx = IDLE;
            end
`endif
          end else begin
            idx_nx = idx + 2'd1;
            sel_nx = sel_of(idx + 2'd1);
          end
        end
      end
      PARITY: begin
        if (beat_fire) begin
          if (accept) begin
            state_nx = SHIFT;
            idx_nx   = '0;
            sel_nx   = sel_of('0);
            word_nx  = bus.in_data;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      sel   <= '0;
      word  <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      sel   <= sel_nx;
      word  <= word_nx;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_last  = out_last_c;
  assign bus.busy      = (state != IDLE);
`ifdef SERIALIZER_PARITY_EN
  assign bus.out_bit   = (state == PARITY) ? even_parity(word) : mux_bit;
`else
  assign bus.out_bit   = mux_bit;
`endif

endmodule

// File: tb/tb_nibble_serializer.sv
// tb/tb_nibble_serializer.sv - randomized and directed bench for nibble_serializer, both beat orders
module tb_nibble_serializer;

`ifdef SERIALIZER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB = 4 + PAR;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] in_data = 4'd0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;

  always #5 clk = ~clk;

  nibble_serializer_if ifa ();
  nibble_serializer_if ifb ();

  assign ifa.in_data   = in_data;
  assign ifa.in_valid  = in_valid;
  assign ifa.out_ready = out_ready;
  assign ifb.in_data   = in_data;
  assign ifb.in_valid  = in_valid;
  assign ifb.out_ready = out_ready;

  nibble_serializer #(.LSB_FIRST(1)) dut_lsb (.clk(clk), .rst(rst), .bus(ifa));
  nibble_serializer #(.LSB_FIRST(0)) dut_msb (.clk(clk), .rst(rst), .bus(ifb));

  logic v [2], b [2], l [2], rdy [2], bsy [2];
  assign v[0] = ifa.out_valid;  assign v[1] = ifb.out_valid;
  assign b[0] = ifa.out_bit;    assign b[1] = ifb.out_bit;
  assign l[0] = ifa.out_last;   assign l[1] = ifb.out_last;
  assign rdy[0] = ifa.in_ready; assign rdy[1] = ifb.in_ready;
  assign bsy[0] = ifa.busy;     assign bsy[1] = ifb.busy;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per DUT, a queue of pending {bit,last} beats.
  logic [1:0] q [2][$];
  logic [31:0] bit_log [2];
  logic [31:0] last_log [2];
  int cyc = 0;
  int valid_cycles = 0;
  int rdy_pulses = 0;
  int first_v = -1;
  int last_v = -1;

  task automatic push_word(input int i, input logic [3:0] w);
    for (int k = 0; k < 4; k++) begin
      int pos;
      pos = (i == 0) ? k : 3 - k;
      q[i].push_back({w[pos], (k == 3 && PAR == 0) ? 1'b1 : 1'b0});
    end
    if (PAR != 0) q[i].push_back({^w, 1'b1});
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      q[0].delete();
      q[1].delete();
    end else begin
      if (v[0]) begin
        valid_cycles++;
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
      end
      if (rdy[0] && v[0]) rdy_pulses++;
      for (int i = 0; i < 2; i++) begin
        logic exp_v, exp_rdy;
        exp_v   = (q[i].size() != 0);
        exp_rdy = (q[i].size() == 0) || (q[i].size() == 1 && out_ready);
        chk($sformatf("out_valid[%0d]", i), v[i], exp_v);
        chk($sformatf("busy[%0d]", i), bsy[i], exp_v);
        chk($sformatf("in_ready[%0d]", i), rdy[i], exp_rdy);
        if (exp_v) begin
          chk($sformatf("out_bit[%0d]", i), b[i], q[i][0][1]);
          chk($sformatf("out_last[%0d]", i), l[i], q[i][0][0]);
        end
        if (v[i] && out_ready) begin
          if (exp_v) void'(q[i].pop_front());
          bit_log[i]  = {bit_log[i][30:0], b[i]};
          last_log[i] = {last_log[i][30:0], l[i]};
        end
        if (in_valid && exp_rdy) push_word(i, in_data);
      end
    end
  end

  task automatic clear_logs();
    bit_log[0] = '0; bit_log[1] = '0;
    last_log[0] = '0; last_log[1] = '0;
    valid_cycles = 0; rdy_pulses = 0; first_v = -1; last_v = -1;
  endtask

  task automatic send(input logic [3:0] w);
    logic ok;
    ok = 1'b0;
    in_data  = w;
    in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (rdy[0]) begin ok = 1'b1; break; end
    end
    if (!ok) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!v[0] && !v[1]) begin ok = 1'b1; break; end
    end
    if (!ok) chk("idle_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  function automatic int msk(input logic [31:0] x);
    return int'(x & ((32'd1 << NB) - 32'd1));
  endfunction

  initial begin
    // Reset
    repeat (2) begin
      @(negedge clk);
      chk("rst_out_valid", v[0] | v[1], 0);
      chk("rst_busy", bsy[0] | bsy[1], 0);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", rdy[0] & rdy[1], 1);
    @(posedge clk); #1;

    // Single words, both orders
    out_ready = 1'b1;
    clear_logs();
    send(4'b0110); in_valid = 1'b0; wait_idle();
    chk("w0110_lsb", msk(bit_log[0]), PAR ? 5'b01100 : 4'b0110);
    chk("w0110_msb", msk(bit_log[1]), PAR ? 5'b01100 : 4'b0110);
    chk("w0110_last", msk(last_log[0]), 1);
    chk("w0110_cycles", valid_cycles, NB);
    clear_logs();
    send(4'b1011); in_valid = 1'b0; wait_idle();
    chk("w1011_lsb", msk(bit_log[0]), PAR ? 5'b11011 : 4'b1101);
    chk("w1011_msb", msk(bit_log[1]), PAR ? 5'b10111 : 4'b1011);
    chk("w1011_last", msk(last_log[1]), 1);

    // Back-to-back with in_valid held
    clear_logs();
    send(4'b1010); send(4'b0011); in_valid = 1'b0; wait_idle();
    chk("b2b_lsb", int'(bit_log[0][2*NB-1:0]), PAR ? 10'b0101011000 : 8'b01011100);
    chk("b2b_msb", int'(bit_log[1][2*NB-1:0]), PAR ? 10'b1010000110 : 8'b10100011);
    chk("b2b_span", last_v - first_v + 1, 2 * NB);
    chk("b2b_valid_cycles", valid_cycles, 2 * NB);
    chk("b2b_ready_pulses", rdy_pulses, 2);

    // Backpressure on beat 2
    clear_logs();
    send(4'b1001); in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    wait_idle();
    chk("bp_lsb", msk(bit_log[0]), PAR ? 5'b10010 : 4'b1001);
    chk("bp_msb", msk(bit_log[1]), PAR ? 5'b10010 : 4'b1001);
    chk("bp_cycles", valid_cycles, NB + 3);

    // Reset mid-word
    send(4'b1111); in_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", v[0] | v[1], 0);
    chk("midrst_in_ready", rdy[0] & rdy[1], 1);
    @(posedge clk); #1;
    clear_logs();
    send(4'b0001); in_valid = 1'b0; wait_idle();
    chk("midrst_lsb", msk(bit_log[0]), PAR ? 5'b10001 : 4'b1000);
    chk("midrst_msb", msk(bit_log[1]), PAR ? 5'b00011 : 4'b0001);

    // Parity-specific words
    clear_logs();
    send(4'b0111); in_valid = 1'b0; wait_idle();
    chk("w0111_lsb", msk(bit_log[0]), PAR ? 5'b11101 : 4'b1110);
    chk("w0111_last", msk(last_log[0]), 1);
    clear_logs();
    send(4'b0000); in_valid = 1'b0; wait_idle();
    chk("w0000_lsb", msk(bit_log[0]), 0);
    chk("w0000_cycles", valid_cycles, NB);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      in_data   = 4'($urandom);
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 250) == 0) begin
        in_valid = 1'b0;
        rst = 1'b1;
      end else begin
        rst = 1'b0;
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    chk("drain_q_lsb", q[0].size(), 0);
    chk("drain_q_msb", q[1].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
